i2c_bus_arbiter: RTL
====================

// Module: i2c_bus_arbiter
// PURPOSE
//  Shares the single I2C byte-level master (RD/WE/DIN/DOUT/QUEUED/NACK/STOP/DATA_VALID, TIC-paced)
//  between two requesters, e.g. the MPU6050 sequencer and a second sensor/EEPROM sequencer.
//  Round-robin grant, held for a whole transaction; muxes commands in and routes status back.
//  A TIC-based watchdog recovers a hung master via SRST and revokes the stuck grant.
// PARAMETERS
//  HOLDOFF_TICS  4    TIC periods of bus idle enforced between a release and the next grant
//  TIMEOUT_TICS  255  TIC periods with no master strobe while granted before watchdog fires (1..255)
// PORTS
//  MCLK          in   1  system clock
//  nRST          in   1  reset, asynchronous, active-low
//  TIC           in   1  master pacing strobe, 1 MCLK wide; every timer below advances only on TIC
//  REQ           in   2  per-client request, level; held high for the whole transaction
//  GNT           out  2  one-hot-or-zero grant, registered
//  C_RD          in   2  per-client read command
//  C_WE          in   2  per-client write command
//  C_DIN0        in   8  client 0 write byte
//  C_DIN1        in   8  client 1 write byte
//  C_QUEUED      out  2  master QUEUED, routed to the granted client only
//  C_NACK        out  2  master NACK, routed to the granted client only
//  C_STOP        out  2  master STOP, routed to the granted client only
//  C_DATA_VALID  out  2  master DATA_VALID, routed to the granted client only
//  C_DOUT        out  8  master read byte, broadcast; valid only with the client's C_DATA_VALID
//  M_RD          out  1  to master RD
//  M_WE          out  1  to master WE
//  M_DIN         out  8  to master DIN
//  M_SRST        out  1  to master SRST (synchronous soft reset)
//  M_QUEUED      in   1  from master
//  M_NACK        in   1  from master
//  M_STOP        in   1  from master
//  M_DATA_VALID  in   1  from master
//  M_DOUT        in   8  from master
//  TIMEOUT       out  1  1-MCLK pulse when the watchdog fires
//  ERR_CNT       out  4  saturating count of watchdog events
// BEHAVIOUR
//  Reset: GNT=0, M_SRST=0, TIMEOUT=0, ERR_CNT=0, LAST=1 (client 0 wins the first tie), state IDLE,
//   all counters 0. Reset mid-transaction drops the grant immediately; M_* commands go to 0 at once.
//  FSM states: IDLE, BUSY, HOLD, RECOVER.
//   IDLE: any REQ high -> BUSY on the next MCLK edge, GNT set to the winner.
//     Winner: single requester wins; if both request, winner = ~LAST. LAST := winner.
//     Latency REQ->GNT is 1 MCLK.
//   BUSY: M_RD = C_RD[g]&GNT[g], M_WE = C_WE[g]&GNT[g], M_DIN = DIN of granted client.
//     Non-granted commands are ignored and never reach the master.
//     Status inputs are ANDed with GNT per client; combinational, 0-cycle route.
//     Granted REQ low -> HOLD: GNT=0, holdoff counter cleared.
//     Watchdog counter cleared on any MCLK where M_QUEUED|M_NACK|M_STOP|M_DATA_VALID; else +1 per TIC.
//     Counter reaching TIMEOUT_TICS -> RECOVER.
//   HOLD: counter +1 per TIC; at HOLDOFF_TICS -> IDLE. REQ ignored here, even from the other client.
//   RECOVER: GNT=0, TIMEOUT pulses 1 MCLK on entry, ERR_CNT+1 (saturates at 15).
//     M_SRST held high from entry through the next TIC (inclusive), then -> HOLD.
//     LAST keeps the timed-out client, so the other client has priority next.
//  Simultaneous events in BUSY: REQ drop and timeout on the same cycle -> timeout wins (RECOVER).
//  Strobe and timeout boundary in the same cycle -> strobe clears the counter; no timeout.
//  A client that re-raises REQ after release waits for HOLD plus arbitration; no back-to-back grant skip.
//  GNT never has both bits set; GNT changes only on state transitions.
// TESTING
//  Reset: hold nRST=0, toggle REQ=11 -> GNT=00, M_RD=M_WE=M_SRST=0, ERR_CNT=0.
//  Tie: REQ=11 from IDLE -> GNT=01 after 1 MCLK. Client0 drops REQ, client1 holds ->
//   GNT=00 for 4 TICs, then GNT=10.
//  Isolation: GNT=01, client1 drives C_WE=1, C_DIN1=8'hA5 -> M_WE=0. Master DATA_VALID with
//   M_DOUT=8'h3C -> C_DATA_VALID=01, C_DOUT=8'h3C.
//  Watchdog: GNT=10, no master strobes for 255 TICs -> TIMEOUT pulse, M_SRST high through next TIC,
//   GNT=00, ERR_CNT=1; then REQ=11 -> GNT=01.
//  Boundary: M_QUEUED on the 255th TIC -> no TIMEOUT. Force 16 timeouts -> ERR_CNT stays 15.
//  Async reset while BUSY with M_WE=1 -> M_WE=0 and GNT=00 without waiting for an MCLK edge.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - two-client round-robin arbiter in front of one I2C byte master
// Holds the grant for a whole transaction, enforces TIC holdoff, recovers a hung master via SRST.
module i2c_bus_arbiter #(
    parameter int HOLDOFF_TICS = 4,
    parameter int TIMEOUT_TICS = 255
) (
    input  logic       MCLK,
    input  logic       nRST,
    input  logic       TIC,
    input  logic [1:0] REQ,
    output logic [1:0] GNT,
    input  logic [1:0] C_RD,
    input  logic [1:0] C_WE,
    input  logic [7:0] C_DIN0,
    input  logic [7:0] C_DIN1,
    output logic [1:0] C_QUEUED,
    output logic [1:0] C_NACK,
    output logic [1:0] C_STOP,
    output logic [1:0] C_DATA_VALID,
    output logic [7:0] C_DOUT,
    output logic       M_RD,
    output logic       M_WE,
    output logic [7:0] M_DIN,
    output logic       M_SRST,
    input  logic       M_QUEUED,
    input  logic       M_NACK,
    input  logic       M_STOP,
    input  logic       M_DATA_VALID,
    input  logic [7:0] M_DOUT,
    output logic       TIMEOUT,
    output logic [3:0] ERR_CNT
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, RECOVER} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_TICS - 1);
    localparam logic [7:0] WD_LAST   = 8'(TIMEOUT_TICS - 1);

    state_t     state, state_n;
    logic [1:0] gnt_n;
    logic       last, last_n;
    logic       win;
    logic [7:0] cnt, cnt_n;
    logic [3:0] err_n;
    logic       timeout_n;
    logic       strobe;
    logic       wd_hit;

    assign strobe = M_QUEUED | M_NACK | M_STOP | M_DATA_VALID;
    // A strobe in the boundary cycle clears the counter, so it suppresses the timeout.
    assign wd_hit = !strobe && TIC && (cnt == WD_LAST);

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            GNT     <= 2'b00;
            last    <= 1'b1;
            cnt     <= 8'd0;
            ERR_CNT <= 4'd0;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_n;
            GNT     <= gnt_n;
            last    <= last_n;
            cnt     <= cnt_n;
            ERR_CNT <= err_n;
            TIMEOUT <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = GNT;
        last_n    = last;
        cnt_n     = cnt;
        err_n     = ERR_CNT;
        timeout_n = 1'b0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = 8'd0;
                if (REQ != 2'b00) begin
                    win     = (REQ == 2'b11) ? ~last : REQ[1];
                    state_n = BUSY;
                    gnt_n   = win ? 2'b10 : 2'b01;
                    last_n  = win;
                end
            end
            BUSY: begin
                if (strobe)
                    cnt_n = 8'd0;
                else if (TIC)
                    cnt_n = cnt + 8'd1;
                if (wd_hit) begin
                    state_n   = RECOVER;
                    gnt_n     = 2'b00;
                    cnt_n     = 8'd0;
                    timeout_n = 1'b1;
                    if (ERR_CNT != 4'hF)
                        err_n = ERR_CNT + 4'd1;
                end else if ((REQ & GNT) == 2'b00) begin
                    state_n = HOLD;
                    gnt_n   = 2'b00;
                    cnt_n   = 8'd0;
                end
            end
            HOLD: begin
                if (TIC) begin
                    if (cnt == HOLD_LAST) begin
                        state_n = IDLE;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            RECOVER: begin
                if (TIC) begin
                    state_n = HOLD;
                    cnt_n   = 8'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Command and status routing is gated by the registered grant, so reset removes it at once.
    assign M_RD   = |(C_RD & GNT);
    assign M_WE   = |(C_WE & GNT);
    assign M_DIN  = GNT[1] ? C_DIN1 : (GNT[0] ? C_DIN0 : 8'h00);
    assign M_SRST = (state == RECOVER);

    assign C_QUEUED     = {2{M_QUEUED}} & GNT;
    assign C_NACK       = {2{M_NACK}} & GNT;
    assign C_STOP       = {2{M_STOP}} & GNT;
    assign C_DATA_VALID = {2{M_DATA_VALID}} & GNT;
    assign C_DOUT       = M_DOUT;

endmodule
